// File: rtl/enemy_laser_scheduler.sv
// enemy_laser_scheduler: shares a single enemy laser among 8 enemies.
// A rotating-priority arbiter picks the shooter in IDLE. The laser then
// descends one LASER_STEP per tick until it leaves play. A cooldown
// down-counter keeps the laser unavailable for COOLDOWN_TICKS ticks.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no laser in flight; grant the next requester while playing
// FLY   | laser descending one LASER_STEP per tick
// COOL  | laser gone; count down COOLDOWN_TICKS ticks before IDLE
module enemy_laser_scheduler #(
  parameter int COOLDOWN_TICKS = 30,
  parameter int LASER_STEP     = 4,
  parameter int LASER_BOTTOM   = 400,
  parameter int LASER_OFFSET   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  game_state,
  input  logic        tick,
  input  logic [7:0]  req,
  input  logic [79:0] enemy_h_bus,
  input  logic [79:0] enemy_v_bus,
  output logic [7:0]  grant,
  output logic        laser_active,
  output logic [9:0]  laser_h,
  output logic [9:0]  laser_v,
  output logic [1:0]  sched_state
);

  // Counter is at least 8 bits and always wide enough for the reload value.
  localparam int CW = ($clog2(COOLDOWN_TICKS + 1) > 8) ? $clog2(COOLDOWN_TICKS + 1) : 8;

  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_TICKS);
  localparam logic [10:0]   STEP_W    = 11'(LASER_STEP);
  localparam logic [10:0]   BOTTOM_W  = 11'(LASER_BOTTOM);
  localparam logic [9:0]    OFFSET_W  = 10'(LASER_OFFSET);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [2:0]    ptr_q, ptr_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [7:0]    grant_q, grant_n;
  logic          active_q, active_n;
  logic [9:0]    lh_q, lh_n;
  logic [9:0]    lv_q, lv_n;

  logic          found;
  logic [2:0]    win;
  logic [2:0]    idx;
  logic [10:0]   sum;
  logic          playing;

  assign playing = (game_state == 2'd1);

  // Rotating-priority search: first set req bit at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 3'd0;
      cnt_q    <= '0;
      grant_q  <= 8'd0;
      active_q <= 1'b0;
      lh_q     <= 10'd1023;
      lv_q     <= 10'd0;
    end else begin
      state_q  <= state_n;
      ptr_q    <= ptr_n;
      cnt_q    <= cnt_n;
      grant_q  <= grant_n;
      active_q <= active_n;
      lh_q     <= lh_n;
      lv_q     <= lv_n;
    end
  end

  // Next-state and next-register logic; leaving play overrides everything.
  always_comb begin
    state_n  = state_q;
    ptr_n    = ptr_q;
    cnt_n    = cnt_q;
    grant_n  = 8'd0;
    active_n = active_q;
    lh_n     = lh_q;
    lv_n     = lv_q;
    sum      = {1'b0, lv_q} + STEP_W;

    if (!playing) begin
      state_n  = IDLE;
      active_n = 1'b0;
      cnt_n    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_n  = 8'd1 << win;
            lh_n     = enemy_h_bus[int'(win)*10 +: 10];
            lv_n     = enemy_v_bus[int'(win)*10 +: 10] + OFFSET_W;
            active_n = 1'b1;
            ptr_n    = win + 3'd1;
            state_n  = FLY;
          end
        end
        FLY: begin
          if (tick) begin
            if (sum >= BOTTOM_W) begin
              active_n = 1'b0;
              cnt_n    = COOL_LOAD;
              state_n  = COOL;
            end else begin
              lv_n = sum[9:0];
            end
          end
        end
        COOL: begin
          if (tick) begin
            if (cnt_q <= CW'(1)) begin
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              cnt_n = cnt_q - CW'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Position outputs are masked whenever no laser is in flight.
  always_comb begin
    grant        = grant_q;
    laser_active = active_q;
    laser_h      = active_q ? lh_q : 10'd1023;
    laser_v      = active_q ? lv_q : 10'd0;
    sched_state  = state_q;
  end

endmodule

// File: tb/tb_enemy_laser_scheduler.sv
// Randomized and directed bench for enemy_laser_scheduler against a
// behavioural model of the shared-laser rules.
module tb_enemy_laser_scheduler;

  localparam int COOLDOWN = 30;
  localparam int STEP     = 4;
  localparam int BOTTOM   = 400;
  localparam int OFFSET   = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  game_state;
  logic        tick;
  logic [7:0]  req;
  logic [79:0] enemy_h_bus;
  logic [79:0] enemy_v_bus;
  logic [7:0]  grant;
  logic        laser_active;
  logic [9:0]  laser_h;
  logic [9:0]  laser_v;
  logic [1:0]  sched_state;

  int n_checks = 0;
  int n_err    = 0;

  // model state: phase 0 idle, 1 flying, 2 cooling
  int m_phase, m_ptr, m_cnt, m_h, m_v, m_g;
  bit m_act;
  int eh[8];
  int ev[8];

  enemy_laser_scheduler #(
    .COOLDOWN_TICKS(COOLDOWN), .LASER_STEP(STEP),
    .LASER_BOTTOM(BOTTOM), .LASER_OFFSET(OFFSET)
  ) dut (
    .clk(clk), .reset(reset), .game_state(game_state), .tick(tick), .req(req),
    .enemy_h_bus(enemy_h_bus), .enemy_v_bus(enemy_v_bus), .grant(grant),
    .laser_active(laser_active), .laser_h(laser_h), .laser_v(laser_v),
    .sched_state(sched_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_cnt = 0; m_h = 1023; m_v = 0; m_g = 0; m_act = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".grant"}, 32'(grant), 32'(m_g));
    check_val({tag, ".active"}, 32'(laser_active), 32'(m_act));
    check_val({tag, ".h"}, 32'(laser_h), m_act ? 32'(m_h) : 32'd1023);
    check_val({tag, ".v"}, 32'(laser_v), m_act ? 32'(m_v) : 32'd0);
    check_val({tag, ".state"}, 32'(sched_state), 32'(m_phase));
  endtask

  // Apply current inputs, advance the model one edge, then compare.
  task automatic step(input string tag);
    int w;
    for (int i = 0; i < 8; i++) begin
      enemy_h_bus[10*i +: 10] = 10'(eh[i]);
      enemy_v_bus[10*i +: 10] = 10'(ev[i]);
    end
    m_g = 0;
    if (game_state != 2'd1) begin
      m_phase = 0; m_act = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      w = -1;
      for (int k = 0; k < 8; k++)
        if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      if (w >= 0) begin
        m_g = 1 << w;
        m_h = eh[w];
        m_v = (ev[w] + OFFSET) % 1024;
        m_act = 1;
        m_ptr = (w + 1) % 8;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (tick) begin
        if (m_v + STEP >= BOTTOM) begin
          m_act = 0; m_phase = 2; m_cnt = COOLDOWN;
        end else m_v = m_v + STEP;
      end
    end else begin
      if (tick) begin
        if (m_cnt <= 1) begin m_cnt = 0; m_phase = 0; end
        else m_cnt = m_cnt - 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("reset");
    reset = 1'b0;
  endtask

  // Step until the model issues a grant; an expired budget is a failure.
  task automatic run_until_grant(input string tag);
    int n;
    n = 0;
    step(tag);
    while (m_g == 0 && n < 600) begin
      step(tag);
      n++;
    end
    check_val({tag, ".timeout"}, 32'(n >= 600), 32'd0);
  endtask

  initial begin
    reset = 1'b1; game_state = 2'd1; tick = 1'b0; req = 8'd0;
    enemy_h_bus = '0; enemy_v_bus = '0;
    for (int i = 0; i < 8; i++) begin eh[i] = 10 * i; ev[i] = 5 * i; end
    #2;
    do_reset();

    // first shot: enemy 2 at (100, 50)
    eh[2] = 100; ev[2] = 50; req = 8'h04;
    step("shot1");
    check_val("shot1.grant_k", 32'(grant), 32'h04);
    check_val("shot1.h_k", 32'(laser_h), 32'd100);
    check_val("shot1.v_k", 32'(laser_v), 32'd70);
    check_val("shot1.state_k", 32'(sched_state), 32'd1);
    req = 8'h00; tick = 1'b1;
    for (int i = 0; i < 82; i++) step("fly");
    check_val("fly82.v_k", 32'(laser_v), 32'd398);
    check_val("fly82.active_k", 32'(laser_active), 32'd1);
    step("fly83");
    check_val("fly83.active_k", 32'(laser_active), 32'd0);
    check_val("fly83.h_k", 32'(laser_h), 32'd1023);
    check_val("fly83.state_k", 32'(sched_state), 32'd2);
    for (int i = 0; i < 29; i++) step("cool");
    check_val("cool29.state_k", 32'(sched_state), 32'd2);
    step("cool30");
    check_val("cool30.state_k", 32'(sched_state), 32'd0);

    // round robin with all enemies requesting
    do_reset();
    req = 8'hFF; tick = 1'b1;
    for (int s = 0; s < 5; s++) begin
      run_until_grant("rr");
      check_val("rr.grant_k", 32'(grant), 32'(1 << s));
    end

    // wrap from ptr = 2
    do_reset();
    req = 8'h02;
    run_until_grant("wrap0");
    check_val("wrap0.grant_k", 32'(grant), 32'h02);
    req = 8'h81;
    run_until_grant("wrap1");
    check_val("wrap1.grant_k", 32'(grant), 32'h80);
    run_until_grant("wrap2");
    check_val("wrap2.grant_k", 32'(grant), 32'h01);

    // leaving play mid-flight
    for (int i = 0; i < 3; i++) step("midfly");
    game_state = 2'd2; req = 8'hFF;
    step("leave");
    check_val("leave.active_k", 32'(laser_active), 32'd0);
    check_val("leave.state_k", 32'(sched_state), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step("notplay");
      check_val("notplay.grant_k", 32'(grant), 32'd0);
    end
    game_state = 2'd1;

    // asynchronous reset mid-cooldown
    do_reset();
    req = 8'hFF;
    run_until_grant("prec");
    begin
      int n;
      n = 0;
      while (m_phase != 2 && n < 600) begin step("tocool"); n++; end
      check_val("tocool.timeout", 32'(n >= 600), 32'd0);
    end
    step("cool_a"); step("cool_b");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    #2 reset = 1'b0;
    step("post_rst");
    check_val("post_rst.grant_k", 32'(grant), 32'h01);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      game_state = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      tick = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: req = 8'd0;
        1: req = 8'd1 << $urandom_range(0, 7);
        default: req = 8'($urandom);
      endcase
      for (int i = 0; i < 8; i++) begin
        eh[i] = $urandom_range(0, 1023);
        ev[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 1023);
      end
      if ($urandom_range(0, 799) == 0) do_reset();
      else step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/enemy_laser_scheduler.md
ENEMY_LASER_SCHEDULER -- requirements
Module: enemy_laser_scheduler

Interface
REQ-001 Parameter COOLDOWN_TICKS, default 30, ticks laser stays unavailable after a shot ends.
REQ-002 Parameter LASER_STEP, default 4, pixels the laser descends per tick.
REQ-003 Parameter LASER_BOTTOM, default 400, vertical position at which the laser leaves play.
REQ-004 Parameter LASER_OFFSET, default 20, vertical offset from enemy top to laser spawn.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 game_state  input  2  game state; 1 = playing, all other values = not playing.
REQ-008 tick  input  1  one-cycle frame-advance pulse.
REQ-009 req  input  8  fire request per enemy; bit i = enemy i alive and wants to fire.
REQ-010 enemy_h_bus  input  80  packed horizontal positions; bits [10i+9:10i] = enemy i.
REQ-011 enemy_v_bus  input  80  packed vertical positions; bits [10i+9:10i] = enemy i.
REQ-012 grant  output  8  one-hot, one-cycle pulse naming the enemy that fired.
REQ-013 laser_active  output  1  laser in flight.
REQ-014 laser_h  output  10  laser horizontal position; 1023 when laser_active = 0.
REQ-015 laser_v  output  10  laser vertical position; 0 when laser_active = 0.
REQ-016 sched_state  output  2  current FSM state encoding.

Function
REQ-017 FSM states SHALL be IDLE = 0, FLY = 1, COOL = 2; encoding 3 SHALL return to IDLE on the next edge.
REQ-018 Only one laser SHALL exist at a time; the scheduler shares it among the 8 enemies.
REQ-019 IDLE with game_state = 1 and req != 0: next edge SHALL issue grant to the winner, load laser_h = enemy_h[w], laser_v = enemy_v[w] + LASER_OFFSET (10-bit truncation), set laser_active = 1, enter FLY.
REQ-020 Winner SHALL be the first set req bit searching upward from pointer ptr, wrapping 7 to 0.
REQ-021 On grant, ptr SHALL become (w + 1) mod 8; ptr SHALL be unchanged otherwise.
REQ-022 grant SHALL be high for exactly the grant cycle and zero in every other cycle.
REQ-023 tick SHALL be ignored in the cycle a grant is issued.
REQ-024 FLY, on tick: sum = laser_v + LASER_STEP computed 11 bits wide; if sum >= LASER_BOTTOM then laser_active = 0 and go to COOL, else laser_v = sum.
REQ-025 FLY without tick: all registers SHALL hold.
REQ-026 Entering COOL SHALL load cooldown counter cnt = COOLDOWN_TICKS.
REQ-027 COOL, on tick: if cnt <= 1 then cnt = 0 and go to IDLE, else cnt = cnt - 1; COOLDOWN_TICKS = 0 exits on first tick.
REQ-028 req SHALL be ignored outside IDLE; no queuing of requests.
REQ-029 game_state != 1 in any state: next edge SHALL force IDLE, laser_active = 0, cnt = 0, grant = 0; ptr is held.
REQ-030 game_state leaving 1 in the same cycle as a pending req SHALL produce no grant.
REQ-031 laser_h/laser_v outputs SHALL be masked to 1023/0 combinationally from laser_active.
REQ-032 The cnt width SHALL hold COOLDOWN_TICKS without overflow (at least 8 bits).

Reset
REQ-033 On reset: state = IDLE, ptr = 0, cnt = 0, grant = 0, laser_active = 0, laser_h = 1023, laser_v = 0, sched_state = 0.
REQ-034 Reset asserted mid-FLY or mid-COOL SHALL abort immediately to reset values, with no grant pulse.

Verification
REQ-035 reset, game_state = 1, req = 8'b0000_0100, enemy 2 at h = 100, v = 50 -> next edge grant = 8'h04, laser_h = 100, laser_v = 70, sched_state = 1.
REQ-036 Laser at v = 70, 83 ticks -> v = 398 after 82 ticks; tick 83 (402 >= 400) -> laser_active = 0, laser_h = 1023, sched_state = 2.
REQ-037 COOL with COOLDOWN_TICKS = 30 -> IDLE after exactly the 30th tick, not the 29th.
REQ-038 req = 8'hFF held across five shots from reset -> grants 0x01, 0x02, 0x04, 0x08, 0x10; req = 8'h81 with ptr = 2 -> grant 0x80, then 0x01.
REQ-039 game_state 1 -> 2 mid-FLY -> next edge laser_active = 0, sched_state = 0, and no grant while game_state = 2 despite req = 8'hFF.
REQ-040 Reset pulse mid-COOL -> all outputs at reset values asynchronously; first IDLE grant afterward uses ptr = 0.
